excp_arbiter: RTL and testbench

- Exception arbitration stage between the MEM stage and the CP0 register block.
- Gathers per-instruction exception flags and pending interrupts from MEM, applies MIPS priority, and registers one exception record per retiring instruction.
- CP0 commits that record on its next unstalled edge.
- Also drives the pipeline flush and redirect PC (exception vector or EPC for eret), and keeps a wrapping exception counter for performance monitoring.

---
 rtl/excp_arbiter.sv | 161 ++++++++++++++++
 tb/tb_excp_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/excp_arbiter.sv
// Exception arbitration between MEM and CP0: picks the highest-priority exception,
// registers one record per retiring instruction, and drives flush/redirect.
module excp_arbiter #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              mem_valid_i,
    input  logic [31:0]       mem_pc_i,
    input  logic              mem_in_delayslot_i,
    input  logic              if_adel_i,
    input  logic              ri_i,
    input  logic              ov_i,
    input  logic              syscall_i,
    input  logic              break_i,
    input  logic              eret_i,
    input  logic              ld_adel_i,
    input  logic              st_ades_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       cp0_status_i,
    input  logic [31:0]       cp0_cause_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic              wb_cp0_we_i,
    input  logic [4:0]        wb_cp0_waddr_i,
    input  logic [31:0]       wb_cp0_data_i,
    output logic [31:0]       excepttype_o,
    output logic [31:0]       excp_pc_o,
    output logic              excp_delayslot_o,
    output logic [31:0]       bad_addr_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic [CNT_W-1:0]  exc_count_o
);

    localparam logic [4:0]  REG_STATUS = 5'd12;
    localparam logic [4:0]  REG_CAUSE  = 5'd13;
    localparam logic [4:0]  REG_EPC    = 5'd14;
    localparam logic [31:0] CODE_INT   = 32'h01;
    localparam logic [31:0] CODE_ADEL  = 32'h04;
    localparam logic [31:0] CODE_ADES  = 32'h05;
    localparam logic [31:0] CODE_SYS   = 32'h08;
    localparam logic [31:0] CODE_BP    = 32'h09;
    localparam logic [31:0] CODE_RI    = 32'h0a;
    localparam logic [31:0] CODE_OV    = 32'h0c;
    localparam logic [31:0] CODE_ERET  = 32'h0e;

    typedef enum logic {
        IDLE,
        REPORT
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       status_eff, cause_eff, epc_eff;
    logic              int_pend;
    logic [31:0]       win_code, win_bad;
    logic [31:0]       type_nxt, pc_nxt, bad_nxt;
    logic              ds_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              unused_bits;

    // Forward an mtc0 still in flight so arbitration sees the value CP0 is about to hold.
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == REG_STATUS) status_eff = wb_cp0_data_i;
            if (wb_cp0_waddr_i == REG_CAUSE)  cause_eff[9:8] = wb_cp0_data_i[9:8];
            if (wb_cp0_waddr_i == REG_EPC)    epc_eff = wb_cp0_data_i;
        end
    end

    assign int_pend = status_eff[0] & ~status_eff[1] &
                      (|(cause_eff[15:8] & status_eff[15:8]));

    assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                           cause_eff[31:16], cause_eff[7:0]};

    always_comb begin
        win_code = '0;
        win_bad  = '0;
        if (mem_valid_i) begin
            if (int_pend)       win_code = CODE_INT;
            else if (if_adel_i) begin
                win_code = CODE_ADEL;
                win_bad  = mem_pc_i;
            end
            else if (ri_i)      win_code = CODE_RI;
            else if (ov_i)      win_code = CODE_OV;
            else if (syscall_i) win_code = CODE_SYS;
            else if (break_i)   win_code = CODE_BP;
            else if (eret_i)    win_code = CODE_ERET;
            else if (ld_adel_i) begin
                win_code = CODE_ADEL;
                win_bad  = mem_addr_i;
            end
            else if (st_ades_i) begin
                win_code = CODE_ADES;
                win_bad  = mem_addr_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        type_nxt  = excepttype_o;
        pc_nxt    = excp_pc_o;
        ds_nxt    = excp_delayslot_o;
        bad_nxt   = bad_addr_o;
        cnt_nxt   = exc_count_o;
        flush_o   = 1'b0;
        new_pc_o  = '0;
        case (state)
            IDLE: begin
                if (!stall_i) begin
                    if (win_code != '0) begin
                        type_nxt  = win_code;
                        pc_nxt    = mem_pc_i;
                        ds_nxt    = mem_in_delayslot_i;
                        bad_nxt   = win_bad;
                        cnt_nxt   = exc_count_o + CNT_W'(1);
                        state_nxt = REPORT;
                    end else begin
                        type_nxt = '0;
                    end
                end
            end
            REPORT: begin
                flush_o  = 1'b1;
                new_pc_o = (excepttype_o == CODE_ERET) ? epc_eff : EXC_VECTOR;
                // The instruction now in MEM is on the wrong path; drop it.
                if (!stall_i) begin
                    type_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            excepttype_o     <= '0;
            excp_pc_o        <= '0;
            excp_delayslot_o <= 1'b0;
            bad_addr_o       <= '0;
            exc_count_o      <= '0;
        end else begin
            state            <= state_nxt;
            excepttype_o     <= type_nxt;
            excp_pc_o        <= pc_nxt;
            excp_delayslot_o <= ds_nxt;
            bad_addr_o       <= bad_nxt;
            exc_count_o      <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_excp_arbiter.sv
// Directed self-checking bench for excp_arbiter; counter narrowed to 4 bits to exercise wrap.
module tb_excp_arbiter;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_i, mem_valid_i, mem_in_delayslot_i;
    logic [31:0]   mem_pc_i, mem_addr_i;
    logic          if_adel_i, ri_i, ov_i, syscall_i, break_i, eret_i, ld_adel_i, st_ades_i;
    logic [31:0]   cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic          wb_cp0_we_i;
    logic [4:0]    wb_cp0_waddr_i;
    logic [31:0]   wb_cp0_data_i;
    logic [31:0]   excepttype_o, excp_pc_o, bad_addr_o, new_pc_o;
    logic          excp_delayslot_o, flush_o;
    logic [CW-1:0] exc_count_o;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_cnt  = '0;

    excp_arbiter #(.EXC_VECTOR(32'hBFC00380), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .mem_valid_i(mem_valid_i),
        .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
        .if_adel_i(if_adel_i), .ri_i(ri_i), .ov_i(ov_i), .syscall_i(syscall_i),
        .break_i(break_i), .eret_i(eret_i), .ld_adel_i(ld_adel_i), .st_ades_i(st_ades_i),
        .mem_addr_i(mem_addr_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
        .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
        .wb_cp0_data_i(wb_cp0_data_i), .excepttype_o(excepttype_o), .excp_pc_o(excp_pc_o),
        .excp_delayslot_o(excp_delayslot_o), .bad_addr_o(bad_addr_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o), .exc_count_o(exc_count_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        stall_i = 0; mem_valid_i = 0; mem_in_delayslot_i = 0;
        mem_pc_i = '0; mem_addr_i = '0;
        if_adel_i = 0; ri_i = 0; ov_i = 0; syscall_i = 0; break_i = 0; eret_i = 0;
        ld_adel_i = 0; st_ades_i = 0;
        cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
        wb_cp0_we_i = 0; wb_cp0_waddr_i = '0; wb_cp0_data_i = '0;
    endtask

    // Drive the current inputs for one edge, expect a capture, then release MEM and return to IDLE.
    task automatic one_exc(input string tag, input logic [31:0] code, input logic [31:0] bad);
        step();
        exp_cnt++;
        check_val({tag, "_type"}, excepttype_o, code);
        check_val({tag, "_bad"}, bad_addr_o, bad);
        check_val({tag, "_flush"}, {31'b0, flush_o}, 32'd1);
        clr_inputs();
        step();
        check_val({tag, "_clr"}, excepttype_o, 32'h0);
    endtask

    initial begin
        clr_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        check_val("rst_type", excepttype_o, 32'h0);
        check_val("rst_pc", excp_pc_o, 32'h0);
        check_val("rst_bad", bad_addr_o, 32'h0);
        check_val("rst_flush", {31'b0, flush_o}, 32'h0);
        check_val("rst_newpc", new_pc_o, 32'h0);
        check_val("rst_cnt", {28'b0, exc_count_o}, 32'h0);

        // syscall: full record and one-cycle report
        mem_valid_i = 1; mem_pc_i = 32'hBFC00100; mem_in_delayslot_i = 1; syscall_i = 1;
        step(); exp_cnt++;
        check_val("sys_type", excepttype_o, 32'h08);
        check_val("sys_pc", excp_pc_o, 32'hBFC00100);
        check_val("sys_ds", {31'b0, excp_delayslot_o}, 32'h1);
        check_val("sys_flush", {31'b0, flush_o}, 32'h1);
        check_val("sys_newpc", new_pc_o, 32'hBFC00380);
        clr_inputs();
        step();
        check_val("sys_after_type", excepttype_o, 32'h0);
        check_val("sys_after_flush", {31'b0, flush_o}, 32'h0);
        check_val("sys_after_newpc", new_pc_o, 32'h0);
        check_val("sys_after_cnt", {28'b0, exc_count_o}, 32'h1);

        mem_valid_i = 1; ri_i = 1; ld_adel_i = 1; mem_addr_i = 32'h80000003;
        one_exc("ri_ld", 32'h0a, 32'h0);
        mem_valid_i = 1; ld_adel_i = 1; mem_addr_i = 32'h80000003;
        one_exc("ld", 32'h04, 32'h80000003);
        mem_valid_i = 1; if_adel_i = 1; st_ades_i = 1; mem_pc_i = 32'h00400002; mem_addr_i = 32'h1235;
        one_exc("ifadel", 32'h04, 32'h00400002);
        mem_valid_i = 1; st_ades_i = 1; mem_addr_i = 32'h1235;
        one_exc("st", 32'h05, 32'h1235);
        mem_valid_i = 1; ov_i = 1; syscall_i = 1; break_i = 1;
        one_exc("ov_pri", 32'h0c, 32'h0);
        mem_valid_i = 1; break_i = 1; eret_i = 1; ld_adel_i = 1; mem_addr_i = 32'h7;
        one_exc("bp_pri", 32'h09, 32'h0);

        // bubble with flags must not raise anything
        syscall_i = 1; ov_i = 1;
        step();
        check_val("bubble_type", excepttype_o, 32'h0);
        check_val("bubble_flush", {31'b0, flush_o}, 32'h0);
        clr_inputs();

        // interrupts
        mem_valid_i = 1; ov_i = 1; cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00000400;
        one_exc("int", 32'h01, 32'h0);
        mem_valid_i = 1; ov_i = 1; cp0_status_i = 32'h0000FF03; cp0_cause_i = 32'h00000400;
        one_exc("int_exl", 32'h0c, 32'h0);
        mem_valid_i = 1; cp0_status_i = 32'h0000FF01;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h00000100;
        one_exc("cause_byp", 32'h01, 32'h0);
        mem_valid_i = 1; cp0_status_i = 32'h0000FF01;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h0000FC00;
        step();
        check_val("cause_hi_nobyp", excepttype_o, 32'h0);
        check_val("cause_hi_flush", {31'b0, flush_o}, 32'h0);
        clr_inputs();
        mem_valid_i = 1; cp0_cause_i = 32'h00000400;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000FF01;
        one_exc("status_byp", 32'h01, 32'h0);

        // eret with EPC bypass live during REPORT
        mem_valid_i = 1; eret_i = 1; cp0_epc_i = 32'h1000;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h2000;
        step(); exp_cnt++;
        check_val("eret_type", excepttype_o, 32'h0e);
        check_val("eret_newpc_byp", new_pc_o, 32'h2000);
        mem_valid_i = 0; eret_i = 0; wb_cp0_we_i = 0;
        #1;
        check_val("eret_newpc_epc", new_pc_o, 32'h1000);
        clr_inputs();
        step();
        check_val("eret_clr", excepttype_o, 32'h0);

        // stall in IDLE holds, then stall across REPORT
        stall_i = 1; mem_valid_i = 1; syscall_i = 1; mem_pc_i = 32'h80001000;
        step();
        check_val("idle_stall_type", excepttype_o, 32'h0);
        check_val("idle_stall_flush", {31'b0, flush_o}, 32'h0);
        stall_i = 0;
        step(); exp_cnt++;
        check_val("stall_cap", excepttype_o, 32'h08);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_hold_type", excepttype_o, 32'h08);
            check_val("stall_hold_flush", {31'b0, flush_o}, 32'h1);
        end
        stall_i = 0;
        step();
        check_val("stall_rel_type", excepttype_o, 32'h0);
        check_val("stall_rel_flush", {31'b0, flush_o}, 32'h0);
        clr_inputs();
        step();
        check_val("stall_cnt", {28'b0, exc_count_o}, {28'b0, exp_cnt});

        // reset during REPORT
        mem_valid_i = 1; syscall_i = 1;
        step();
        check_val("rstrep_flush_pre", {31'b0, flush_o}, 32'h1);
        clr_inputs();
        rst = 1;
        step();
        rst = 0; exp_cnt = '0;
        check_val("rstrep_flush", {31'b0, flush_o}, 32'h0);
        check_val("rstrep_type", excepttype_o, 32'h0);
        check_val("rstrep_cnt", {28'b0, exc_count_o}, 32'h0);

        // counter wrap
        for (int i = 0; i < 16; i++) begin
            mem_valid_i = 1; break_i = 1;
            step(); exp_cnt++;
            clr_inputs();
            step();
            if (i == 14) check_val("cnt_15", {28'b0, exc_count_o}, 32'hF);
        end
        check_val("cnt_wrap", {28'b0, exc_count_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
